mor1kx_ibus_burst_responder: RTL and testbench

- Instruction-bus responder: on-chip SRAM target that answers instruction-cache refill and uncached fetch requests on the ibus (req/adr in; ack/err/dat out).
- Serves critical-word-first wrapping block refills.
- Programmable first-word wait states.
- Zero-wait back-to-back acks for in-block sequential words via speculative prefetch.
- Side load port fills memory (boot loader, testbench).

---
 rtl/mor1kx_ibus_burst_responder_pkg.sv | 24 ++
 rtl/mor1kx_simple_dpram_sclk.sv | 43 ++++
 rtl/mor1kx_ibus_burst_responder.sv | 154 +++++++++++++++
 tb/tb_mor1kx_ibus_burst_responder.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mor1kx_ibus_burst_responder_pkg.sv
// Shared ibus responder definitions: one-hot state codes and the
// critical-word-first wrap increment also used by the cache refill logic.
package mor1kx_ibus_burst_responder_pkg;

  typedef logic [3:0] ibus_resp_state_t;

  localparam ibus_resp_state_t IBUS_RESP_IDLE = 4'b0001;
  localparam ibus_resp_state_t IBUS_RESP_WAIT = 4'b0010;
  localparam ibus_resp_state_t IBUS_RESP_ACK  = 4'b0100;
  localparam ibus_resp_state_t IBUS_RESP_ERR  = 4'b1000;

  localparam int unsigned IBUS_WORD_BYTES = 4;
  localparam int unsigned IBUS_CNT_WIDTH  = 4;

  // Next word inside a 2^block_width byte line; the line bits never change,
  // so a burst started mid-line wraps back to offset 0 of the same line.
  function automatic logic [31:0] ibus_wrap_incr(input logic [31:0] adr,
                                                 input int unsigned block_width);
    logic [31:0] mask;
    mask = (32'd1 << block_width) - 32'd1;
    return (adr & ~mask) | ((adr + 32'(IBUS_WORD_BYTES)) & mask);
  endfunction

endpackage

// File: rtl/mor1kx_simple_dpram_sclk.sv
// Single-clock simple dual-port RAM: one synchronous read port, one write port.
// Without bypass, a same-address read/write returns the old contents.
module mor1kx_simple_dpram_sclk #(
  parameter int ADDR_WIDTH    = 12,
  parameter int DATA_WIDTH    = 32,
  parameter     ENABLE_BYPASS = "TRUE"
) (
  input  logic                  clk,
  input  logic [ADDR_WIDTH-1:0] raddr,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic                  we,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  localparam bit BYPASS_EN = (ENABLE_BYPASS == "TRUE");

  logic [DATA_WIDTH-1:0] mem [(2**ADDR_WIDTH)-1:0];
  logic [DATA_WIDTH-1:0] dout_q;
  logic [DATA_WIDTH-1:0] dout_d;

  always_comb begin
    dout_d = dout_q;
    if (re) begin
      if (BYPASS_EN && we && (waddr == raddr)) begin
        dout_d = din;
      end else begin
        dout_d = mem[raddr];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= din;
    end
    dout_q <= dout_d;
  end

  assign dout = dout_q;

endmodule

// File: rtl/mor1kx_ibus_burst_responder.sv
// Instruction-bus SRAM target: wait-stated first word, then zero-wait
// wrapping sequential acks served from a speculative prefetch of the next word.
module mor1kx_ibus_burst_responder
  import mor1kx_ibus_burst_responder_pkg::*;
#(
  parameter int          ADDR_WIDTH  = 12,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          BLOCK_WIDTH = 5,
  parameter int          WAIT_STATES = 2,
  parameter              SEQ_FAST    = "TRUE"
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ibus_req_i,
  input  logic [31:0]           ibus_adr_i,
  output logic                  ibus_ack_o,
  output logic                  ibus_err_o,
  output logic [31:0]           ibus_dat_o,
  input  logic                  load_we_i,
  input  logic [ADDR_WIDTH-1:0] load_adr_i,
  input  logic [31:0]           load_dat_i,
  output logic                  busy_o
);

  localparam int TAG_LSB = ADDR_WIDTH + 2;
  localparam bit SEQ_EN  = (SEQ_FAST == "TRUE");

  // Handshake: the initiator holds ibus_req_i and ibus_adr_i stable until it
  // samples ibus_ack_o or ibus_err_o high on a rising edge; it may present the
  // next address only in the cycle after that ack. Each strobe lasts one cycle
  // and transfers exactly one word (ack) or terminates the request (err).

  ibus_resp_state_t          state_q, state_d;
  logic [IBUS_CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [31:0]               adr_q, adr_d;
  logic                      prefetch_valid_q, prefetch_valid_d;

  logic [ADDR_WIDTH-1:0] raddr;
  logic [31:0]           ram_dout;
  logic [31:0]           nxt;
  logic                  in_range;
  logic                  aligned;
  logic                  seq_hit;
  logic                  nxt_clobbered;
  logic                  ack;
  logic                  err;

  assign in_range = (ibus_adr_i[31:TAG_LSB] == BASE_ADDR[31:TAG_LSB]);
  assign aligned  = (ibus_adr_i[1:0] == 2'b00);
  assign nxt      = ibus_wrap_incr(adr_q, BLOCK_WIDTH);

  // Outside IDLE/ACK adr_q is the word being fetched; after an ack it already
  // holds the wrapped successor, whose data sits prefetched on ram_dout.
  assign seq_hit       = prefetch_valid_q & ibus_req_i & (ibus_adr_i == adr_q);
  assign nxt_clobbered = load_we_i & (load_adr_i == nxt[TAG_LSB-1:2]);

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    adr_d            = adr_q;
    prefetch_valid_d = prefetch_valid_q;
    raddr            = adr_q[TAG_LSB-1:2];
    ack              = 1'b0;
    err              = 1'b0;

    case (state_q)
      IBUS_RESP_IDLE: begin
        if (seq_hit) begin
          ack              = 1'b1;
          adr_d            = nxt;
          raddr            = nxt[TAG_LSB-1:2];
          prefetch_valid_d = SEQ_EN & ~nxt_clobbered;
        end else if (ibus_req_i && !(in_range && aligned)) begin
          state_d          = IBUS_RESP_ERR;
          prefetch_valid_d = 1'b0;
        end else if (ibus_req_i) begin
          state_d          = IBUS_RESP_WAIT;
          adr_d            = ibus_adr_i;
          cnt_d            = IBUS_CNT_WIDTH'(WAIT_STATES);
          raddr            = ibus_adr_i[TAG_LSB-1:2];
          prefetch_valid_d = 1'b0;
        end else begin
          prefetch_valid_d = 1'b0;
        end
      end

      IBUS_RESP_WAIT: begin
        if (!ibus_req_i) begin
          state_d = IBUS_RESP_IDLE;
        end else if (cnt_q == '0) begin
          state_d = IBUS_RESP_ACK;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      IBUS_RESP_ACK: begin
        // A load hitting the word being prefetched makes ram_dout stale.
        ack              = 1'b1;
        adr_d            = nxt;
        raddr            = nxt[TAG_LSB-1:2];
        prefetch_valid_d = SEQ_EN & ~nxt_clobbered;
        state_d          = IBUS_RESP_IDLE;
      end

      IBUS_RESP_ERR: begin
        err     = 1'b1;
        state_d = IBUS_RESP_IDLE;
      end

      default: begin
        state_d          = IBUS_RESP_IDLE;
        prefetch_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IBUS_RESP_IDLE;
      cnt_q            <= '0;
      adr_q            <= '0;
      prefetch_valid_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      adr_q            <= adr_d;
      prefetch_valid_q <= prefetch_valid_d;
    end
  end

  mor1kx_simple_dpram_sclk #(
    .ADDR_WIDTH   (ADDR_WIDTH),
    .DATA_WIDTH   (32),
    .ENABLE_BYPASS("FALSE")
  ) u_ram (
    .clk  (clk),
    .raddr(raddr),
    .re   (1'b1),
    .waddr(load_adr_i),
    .we   (load_we_i),
    .din  (load_dat_i),
    .dout (ram_dout)
  );

  assign ibus_ack_o = ack;
  assign ibus_err_o = err;
  assign ibus_dat_o = ram_dout;
  assign busy_o     = (state_q != IBUS_RESP_IDLE);

  a_state_onehot: assert property (@(posedge clk) disable iff (rst) $onehot(state_q));
  a_strobe_excl:  assert property (@(posedge clk) disable iff (rst) !(ibus_ack_o && ibus_err_o));

endmodule

// File: tb/tb_mor1kx_ibus_burst_responder.sv
// Bench: a fast-sequential responder (2 wait states) and a plain one (0 wait
// states) share clock, reset and load port; a scoreboard checks every strobe.
module tb_mor1kx_ibus_burst_responder;

  localparam int EW      = 65;
  localparam int AW      = 12;
  localparam int WS_FAST = 2;
  localparam int WS_SLOW = 0;

  logic          clk = 1'b0;
  logic          rst;
  logic          req  [2];
  logic [31:0]   adr  [2];
  logic          ack  [2];
  logic          err  [2];
  logic [31:0]   dat  [2];
  logic          busy [2];
  logic          load_we;
  logic [AW-1:0] load_adr;
  logic [31:0]   load_dat;

  // Entry: {is_err, cycle of strobe, data}
  logic [EW-1:0] exp_q0[$];
  logic [EW-1:0] exp_q1[$];
  logic [31:0]   mem_m [0:4095];
  int cyc   = 0;
  int tests = 0;
  int fails = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mor1kx_ibus_burst_responder #(
    .ADDR_WIDTH(AW), .BASE_ADDR(32'h0), .BLOCK_WIDTH(5),
    .WAIT_STATES(WS_FAST), .SEQ_FAST("TRUE")
  ) u_fast (
    .clk(clk), .rst(rst), .ibus_req_i(req[0]), .ibus_adr_i(adr[0]),
    .ibus_ack_o(ack[0]), .ibus_err_o(err[0]), .ibus_dat_o(dat[0]),
    .load_we_i(load_we), .load_adr_i(load_adr), .load_dat_i(load_dat),
    .busy_o(busy[0])
  );

  mor1kx_ibus_burst_responder #(
    .ADDR_WIDTH(AW), .BASE_ADDR(32'h0), .BLOCK_WIDTH(5),
    .WAIT_STATES(WS_SLOW), .SEQ_FAST("FALSE")
  ) u_slow (
    .clk(clk), .rst(rst), .ibus_req_i(req[1]), .ibus_adr_i(adr[1]),
    .ibus_ack_o(ack[1]), .ibus_err_o(err[1]), .ibus_dat_o(dat[1]),
    .load_we_i(load_we), .load_adr_i(load_adr), .load_dat_i(load_dat),
    .busy_o(busy[1])
  );

  // ---------------- reference model helpers ----------------
  function automatic int widx(input logic [31:0] a);
    return int'((a % 32'd16384) / 32'd4);
  endfunction

  function automatic logic [31:0] wrap_next(input logic [31:0] a);
    return (a / 32'd32) * 32'd32 + ((a % 32'd32) + 32'd4) % 32'd32;
  endfunction

  function automatic int first_lat(input int d);
    return (d == 0) ? WS_FAST + 2 : WS_SLOW + 2;
  endfunction

  function automatic void check(input string name, input int d,
                                input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s dut%0d cyc=%0d got=0x%0h expected=0x%0h", name, d, cyc, act, exp);
    end
  endfunction

  function automatic void push_exp(input int d, input logic [EW-1:0] e);
    if (d == 0) exp_q0.push_back(e);
    else        exp_q1.push_back(e);
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [EW-1:0] e;
    for (int d = 0; d < 2; d++) begin
      if (ack[d] || err[d]) begin
        check("ack_err_excl", d, 64'(ack[d] & err[d]), 64'd0);
        if ((d == 0 && exp_q0.size() == 0) || (d == 1 && exp_q1.size() == 0)) begin
          tests++;
          fails++;
          $display("FAIL unexpected_strobe dut%0d cyc=%0d ack=%0b err=%0b, none expected",
                   d, cyc, ack[d], err[d]);
        end else begin
          if (d == 0) e = exp_q0.pop_front();
          else        e = exp_q1.pop_front();
          check("strobe_is_err", d, 64'(err[d]), 64'(e[64]));
          check("strobe_cycle", d, 64'(cyc), 64'(e[63:32]));
          if (!e[64]) check("ack_data", d, 64'(dat[d]), 64'(e[31:0]));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic load_word(input int idx, input logic [31:0] v);
    @(posedge clk); #1;
    load_we  = 1'b1;
    load_adr = AW'(idx);
    load_dat = v;
    mem_m[idx] = v;
    @(posedge clk); #1;
    load_we = 1'b0;
  endtask

  // Initiator following the wrap order; optionally overwrites the word after
  // ack number clob_k during that ack cycle.
  task automatic burst(input int d, input logic [31:0] start, input int n,
                       input int clob_k, input logic [31:0] clob_dat);
    logic [31:0] a;
    logic [31:0] nx;
    bit fast;
    bit seen;
    a    = start;
    fast = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      load_we = 1'b0;
      req[d]  = 1'b1;
      adr[d]  = a;
      push_exp(d, {1'b0, 32'(cyc + (fast ? 0 : first_lat(d))), mem_m[widx(a)]});
      nx   = wrap_next(a);
      seen = 1'b0;
      for (int t = 0; t < 64 && !seen; t++) begin
        @(negedge clk);
        if (ack[d]) seen = 1'b1;
      end
      if (!seen) begin
        tests++;
        fails++;
        $display("FAIL ack_timeout dut%0d adr=0x%0h got=no ack expected=ack", d, a);
        req[d] = 1'b0;
        return;
      end
      if (k == clob_k) begin
        load_we  = 1'b1;
        load_adr = AW'(widx(nx));
        load_dat = clob_dat;
        mem_m[widx(nx)] = clob_dat;
        fast = 1'b0;
      end else begin
        fast = (d == 0);
      end
      a = nx;
    end
    @(posedge clk); #1;
    load_we = 1'b0;
    req[d]  = 1'b0;
    @(negedge clk);
    check("busy_after_burst", d, 64'(busy[d]), 64'd0);
  endtask

  task automatic err_access(input int d, input logic [31:0] a);
    bit seen;
    @(posedge clk); #1;
    req[d] = 1'b1;
    adr[d] = a;
    push_exp(d, {1'b1, 32'(cyc + 1), 32'h0});
    seen = 1'b0;
    for (int t = 0; t < 16 && !seen; t++) begin
      @(negedge clk);
      if (err[d]) seen = 1'b1;
    end
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL err_timeout dut%0d adr=0x%0h got=no err expected=err", d, a);
    end
    @(posedge clk); #1;
    req[d] = 1'b0;
    @(negedge clk);
    check("busy_after_err", d, 64'(busy[d]), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d got=still running expected=finished", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit seen;
    int d;
    int n;
    int ck;
    rst      = 1'b1;
    req      = '{1'b0, 1'b0};
    adr      = '{32'h0, 32'h0};
    load_we  = 1'b0;
    load_adr = '0;
    load_dat = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("reset_ack", i, 64'(ack[i]), 64'd0);
      check("reset_err", i, 64'(err[i]), 64'd0);
      check("reset_busy", i, 64'(busy[i]), 64'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 8; i++) load_word(i, 32'hA0 + 32'(i));

    // Critical-word-first wrapping refill, then illegal and legal singles.
    burst(0, 32'h08, 8, -1, 32'h0);
    err_access(0, 32'h0001_0000);
    err_access(0, 32'h06);
    burst(0, 32'h04, 1, -1, 32'h0);

    // Abort during WAIT, then a fresh access must take the full latency.
    @(posedge clk); #1;
    req[0] = 1'b1;
    adr[0] = 32'h10;
    @(posedge clk); #1;
    req[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("busy_after_abort", 0, 64'(busy[0]), 64'd0);
    burst(0, 32'h14, 1, -1, 32'h0);

    // Overwrite the word being prefetched mid-burst.
    burst(0, 32'h00, 8, 2, 32'h0000_DEAD);

    // Plain responder: every word costs the full first-word latency.
    burst(1, 32'h0C, 8, -1, 32'h0);

    // Reset asserted during an ack cycle.
    @(posedge clk); #1;
    req[1] = 1'b1;
    adr[1] = 32'h00;
    push_exp(1, {1'b0, 32'(cyc + first_lat(1)), mem_m[0]});
    seen = 1'b0;
    for (int t = 0; t < 16 && !seen; t++) begin
      @(negedge clk);
      if (ack[1]) seen = 1'b1;
    end
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL rst_burst_ack dut1 got=no ack expected=ack");
    end
    rst = 1'b1;
    @(posedge clk); #1;
    adr[1] = 32'h04;
    @(negedge clk);
    check("rst_mid_ack", 1, 64'(ack[1]), 64'd0);
    check("rst_mid_err", 1, 64'(err[1]), 64'd0);
    check("rst_mid_busy", 1, 64'(busy[1]), 64'd0);
    @(posedge clk); #1;
    req[1] = 1'b0;
    rst    = 1'b0;

    // Randomized traffic over the first 64 words.
    for (int i = 8; i < 64; i++) load_word(i, $urandom());
    for (int it = 0; it < 40; it++) begin
      d = int'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) begin
        if ($urandom_range(0, 1) == 0)
          err_access(d, 32'h0000_4000 + 32'($urandom_range(0, 4095)) * 32'd4);
        else
          err_access(d, 32'($urandom_range(0, 63)) * 32'd4 + 32'($urandom_range(1, 3)));
      end else begin
        n  = int'($urandom_range(1, 8));
        ck = (n > 1 && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, n - 2)) : -1;
        burst(d, 32'($urandom_range(0, 63)) * 32'd4, n, ck, $urandom());
      end
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    repeat (5) @(posedge clk);
    @(negedge clk);
    check("exp_q0_drained", 0, 64'(exp_q0.size()), 64'd0);
    check("exp_q1_drained", 1, 64'(exp_q1.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
